// File: rtl/pre_neuron_hist_bank.sv
// Purpose : per-neuron pre-synaptic spike-time bitmap bank (set on spike, read on query, swept clear on time reference).
// Latency : events write in 1 cycle; query data 1 cycle after accept; clear sweep takes N_NEUR cycles.
// Backpr. : evt_ready/qry_ready are high in IDLE and low for the whole clear sweep; nothing is queued.
//
// Ports:
//   CLK, RST_sync                  rising-edge clock, synchronous active-high reset
//   evt_valid/evt_ready, evt_addr, current_time_step
//                                  spike event: sets bit current_time_step of row evt_addr
//   qry_valid/qry_ready, qry_addr  row read request
//   qry_rdata_valid, qry_hist, qry_cnt
//                                  registered read data (bitmap + popcount), held until next query
//   time_ref_event, clr_busy, clr_done
//                                  start / status of the sequential row-clear sweep
//   ts_err                         pulse: accepted event carried an out-of-range time step
//
// Build option: define PRE_NEUR_HIST_POPCNT_EN to enable the popcount on qry_cnt;
// when it is undefined the popcount logic is absent and qry_cnt reads 0.
module pre_neuron_hist_bank #(
  parameter int N_NEUR    = 256,
  parameter int TIME_STEP = 8,
  parameter int CNT_WIDTH = $clog2(TIME_STEP + 1)
) (
  input  logic                         CLK,
  input  logic                         RST_sync,
  input  logic                         evt_valid,
  output logic                         evt_ready,
  input  logic [$clog2(N_NEUR)-1:0]    evt_addr,
  input  logic [$clog2(TIME_STEP)-1:0] current_time_step,
  input  logic                         qry_valid,
  output logic                         qry_ready,
  input  logic [$clog2(N_NEUR)-1:0]    qry_addr,
  output logic                         qry_rdata_valid,
  output logic [TIME_STEP-1:0]         qry_hist,
  output logic [CNT_WIDTH-1:0]         qry_cnt,
  input  logic                         time_ref_event,
  output logic                         clr_busy,
  output logic                         clr_done,
  output logic                         ts_err
);

  localparam int AW  = $clog2(N_NEUR);
  localparam int TSW = $clog2(TIME_STEP);
  localparam logic [AW-1:0] LAST_ROW = AW'(N_NEUR - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        clr_ptr_q, clr_ptr_d;
  logic [TIME_STEP-1:0] hist_q [N_NEUR];
  logic [TIME_STEP-1:0] hist_d [N_NEUR];
  logic                 rdv_q, rdv_d;
  logic [TIME_STEP-1:0] qry_hist_q, qry_hist_d;
  logic [CNT_WIDTH-1:0] qry_cnt_q, qry_cnt_d;
  logic                 ts_err_q, ts_err_d;

  logic                 evt_acc;
  logic                 qry_acc;
  logic                 ts_ok;
  logic [TIME_STEP-1:0] rd_row;
  logic [CNT_WIDTH-1:0] rd_cnt;

  assign evt_ready = (state_q == S_IDLE);
  assign qry_ready = (state_q == S_IDLE);
  assign clr_busy  = (state_q == S_CLEAR);
  // Last sweep cycle is the one that clears row N_NEUR-1.
  assign clr_done  = (state_q == S_CLEAR) && (clr_ptr_q == LAST_ROW);

  assign evt_acc = evt_valid & evt_ready;
  assign qry_acc = qry_valid & qry_ready;

  // Read from the pre-write array so a same-cycle event is not visible to the query.
  assign rd_row = hist_q[qry_addr];

  // Out-of-range time steps only exist when TIME_STEP is not a power of two.
  generate
    if ((1 << TSW) > TIME_STEP) begin : g_ts_chk
      assign ts_ok = (current_time_step < TSW'(TIME_STEP));
    end else begin : g_ts_all_legal
      assign ts_ok = 1'b1;
    end
  endgenerate

`ifdef PRE_NEUR_HIST_POPCNT_EN
  always_comb begin
    rd_cnt = '0;
    for (int i = 0; i < TIME_STEP; i++) begin
      rd_cnt = rd_cnt + CNT_WIDTH'(rd_row[i]);
    end
  end
`else
  assign rd_cnt = '0;
`endif

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    hist_d     = hist_q;
    rdv_d      = qry_acc;
    qry_hist_d = qry_hist_q;
    qry_cnt_d  = qry_cnt_q;
    ts_err_d   = 1'b0;

    if (qry_acc) begin
      qry_hist_d = rd_row;
      qry_cnt_d  = rd_cnt;
    end

    if (evt_acc) begin
      if (ts_ok) begin
        hist_d[evt_addr][current_time_step] = 1'b1;
      end else begin
        ts_err_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (time_ref_event) begin
          state_d   = S_CLEAR;
          clr_ptr_d = '0;
        end
      end
      S_CLEAR: begin
        // time_ref_event is deliberately ignored here: no restart, no queueing.
        hist_d[clr_ptr_q] = '0;
        if (clr_ptr_q == LAST_ROW) begin
          state_d   = S_IDLE;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST_sync) begin
      state_q    <= S_IDLE;
      clr_ptr_q  <= '0;
      rdv_q      <= 1'b0;
      qry_hist_q <= '0;
      qry_cnt_q  <= '0;
      ts_err_q   <= 1'b0;
      for (int i = 0; i < N_NEUR; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      rdv_q      <= rdv_d;
      qry_hist_q <= qry_hist_d;
      qry_cnt_q  <= qry_cnt_d;
      ts_err_q   <= ts_err_d;
      hist_q     <= hist_d;
    end
  end

  assign qry_rdata_valid = rdv_q;
  assign qry_hist        = qry_hist_q;
  assign qry_cnt         = qry_cnt_q;
  assign ts_err          = ts_err_q;

endmodule

// File: tb/tb_pre_neuron_hist_bank.sv
// Bench for pre_neuron_hist_bank: directed table, corner sequences, random vs. array model.
module tb_pre_neuron_hist_bank;

  localparam int N   = 256;
  localparam int TS  = 8;
  localparam int CW  = 4;
  localparam int N6  = 4;
  localparam int TS6 = 6;
  localparam int CW6 = 3;
`ifdef PRE_NEUR_HIST_POPCNT_EN
  localparam bit POPCNT = 1'b1;
`else
  localparam bit POPCNT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  // main instance (256 x 8)
  logic          evt_valid, evt_ready, qry_valid, qry_ready, qry_rdata_valid;
  logic [7:0]    evt_addr, qry_addr;
  logic [2:0]    cur_ts;
  logic [TS-1:0] qry_hist;
  logic [CW-1:0] qry_cnt;
  logic          time_ref, clr_busy, clr_done, ts_err;
  // small instance (4 x 6) for the out-of-range time step
  logic           evt6_valid, evt6_ready, qry6_valid, qry6_ready, qry6_rdv;
  logic [1:0]     evt6_addr, qry6_addr;
  logic [2:0]     cur6_ts;
  logic [TS6-1:0] qry6_hist;
  logic [CW6-1:0] qry6_cnt;
  logic           time6_ref, clr6_busy, clr6_done, ts6_err;

  pre_neuron_hist_bank #(.N_NEUR(N), .TIME_STEP(TS)) dut (
    .CLK(clk), .RST_sync(rst),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_addr(evt_addr),
    .current_time_step(cur_ts),
    .qry_valid(qry_valid), .qry_ready(qry_ready), .qry_addr(qry_addr),
    .qry_rdata_valid(qry_rdata_valid), .qry_hist(qry_hist), .qry_cnt(qry_cnt),
    .time_ref_event(time_ref), .clr_busy(clr_busy), .clr_done(clr_done), .ts_err(ts_err)
  );

  pre_neuron_hist_bank #(.N_NEUR(N6), .TIME_STEP(TS6)) dut6 (
    .CLK(clk), .RST_sync(rst),
    .evt_valid(evt6_valid), .evt_ready(evt6_ready), .evt_addr(evt6_addr),
    .current_time_step(cur6_ts),
    .qry_valid(qry6_valid), .qry_ready(qry6_ready), .qry_addr(qry6_addr),
    .qry_rdata_valid(qry6_rdv), .qry_hist(qry6_hist), .qry_cnt(qry6_cnt),
    .time_ref_event(time6_ref), .clr_busy(clr6_busy), .clr_done(clr6_done), .ts_err(ts6_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference: one bitmap per neuron, updated with plain set-bit arithmetic.
  logic [TS-1:0] mh [N];

  typedef struct {
    bit         is_qry;
    logic [7:0] addr;
    logic [2:0] ts;
    logic [7:0] exp_hist;
    int         exp_cnt;
  } vec_t;
  localparam int NV = 11;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ecnt(input int c);
    return POPCNT ? c : 0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) mh[i] = '0;
  endtask

  task automatic do_evt(input logic [7:0] a, input logic [2:0] t);
    evt_valid = 1'b1; evt_addr = a; cur_ts = t;
    step();
    evt_valid = 1'b0;
    mh[a] = mh[a] | 8'(1 << t);
    chk("evt_ts_err", 32'(ts_err), 0);
  endtask

  task automatic do_qry(input string name, input logic [7:0] a, input logic [7:0] eh, input int ec);
    qry_valid = 1'b1; qry_addr = a;
    step();
    qry_valid = 1'b0;
    chk({name, "_vld"}, 32'(qry_rdata_valid), 1);
    chk({name, "_hist"}, 32'(qry_hist), 32'(eh));
    chk({name, "_cnt"}, 32'(qry_cnt), 32'(ecnt(ec)));
    step();
    chk({name, "_vld_pulse"}, 32'(qry_rdata_valid), 0);
    chk({name, "_hold"}, 32'(qry_hist), 32'(eh));
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, "_evt_rdy"}, 32'(evt_ready), 1);
    chk({name, "_qry_rdy"}, 32'(qry_ready), 1);
    chk({name, "_busy"}, 32'(clr_busy), 0);
    chk({name, "_done"}, 32'(clr_done), 0);
    chk({name, "_ts_err"}, 32'(ts_err), 0);
    chk({name, "_rdv"}, 32'(qry_rdata_valid), 0);
    chk({name, "_hist"}, 32'(qry_hist), 0);
    chk({name, "_cnt"}, 32'(qry_cnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy, done, done_at, cyc, rdv_seen;
    logic [7:0] last_hist, exp_q;
    logic [7:0] ea, qa;
    logic [2:0] et;
    bit ev, qv;

    rst = 1'b1;
    evt_valid = 0; evt_addr = 0; cur_ts = 0; qry_valid = 0; qry_addr = 0; time_ref = 0;
    evt6_valid = 0; evt6_addr = 0; cur6_ts = 0; qry6_valid = 0; qry6_addr = 0; time6_ref = 0;
    model_clear();

    vt[0]  = '{1'b0, 8'd5,   3'd0, 8'h00, 0};
    vt[1]  = '{1'b0, 8'd5,   3'd3, 8'h00, 0};
    vt[2]  = '{1'b0, 8'd5,   3'd3, 8'h00, 0};
    vt[3]  = '{1'b0, 8'd5,   3'd7, 8'h00, 0};
    vt[4]  = '{1'b1, 8'd5,   3'd0, 8'h89, 3};
    vt[5]  = '{1'b0, 8'd255, 3'd6, 8'h00, 0};
    vt[6]  = '{1'b0, 8'd255, 3'd0, 8'h00, 0};
    vt[7]  = '{1'b1, 8'd255, 3'd0, 8'h41, 2};
    vt[8]  = '{1'b1, 8'd4,   3'd0, 8'h00, 0};
    vt[9]  = '{1'b0, 8'd0,   3'd1, 8'h00, 0};
    vt[10] = '{1'b1, 8'd0,   3'd0, 8'h02, 1};

    repeat (3) step();
    rst = 1'b0;
    step();
    chk_reset_outs("reset");
    chk("reset6_rdy", 32'(evt6_ready & qry6_ready), 1);
    chk("reset6_outs", 32'({clr6_busy, clr6_done, ts6_err, qry6_rdv}), 0);
    chk("reset6_data", 32'({qry6_hist, qry6_cnt}), 0);

    // Directed table
    for (int i = 0; i < NV; i++) begin
      if (vt[i].is_qry) do_qry("tbl_qry", vt[i].addr, vt[i].exp_hist, vt[i].exp_cnt);
      else do_evt(vt[i].addr, vt[i].ts);
    end

    // Same-cycle event and query to one row: read-before-write
    evt_valid = 1'b1; evt_addr = 8'd9; cur_ts = 3'd2;
    qry_valid = 1'b1; qry_addr = 8'd9;
    step();
    evt_valid = 1'b0; qry_valid = 1'b0;
    mh[9] = mh[9] | 8'h04;
    chk("rbw_vld", 32'(qry_rdata_valid), 1);
    chk("rbw_hist", 32'(qry_hist), 0);
    chk("rbw_cnt", 32'(qry_cnt), 0);
    do_qry("rbw_requery", 8'd9, 8'h04, 1);

    // Out-of-range time step on the 6-step instance
    evt6_valid = 1'b1; evt6_addr = 2'd1; cur6_ts = 3'd6;
    step();
    evt6_valid = 1'b0;
    chk("ts6_err_pulse", 32'(ts6_err), 1);
    step();
    chk("ts6_err_clear", 32'(ts6_err), 0);
    evt6_valid = 1'b1; cur6_ts = 3'd5;
    step();
    evt6_valid = 1'b0;
    chk("ts6_legal_no_err", 32'(ts6_err), 0);
    qry6_valid = 1'b1; qry6_addr = 2'd1;
    step();
    qry6_valid = 1'b0;
    chk("ts6_qry_vld", 32'(qry6_rdv), 1);
    chk("ts6_qry_hist", 32'(qry6_hist), 32'h20);
    chk("ts6_qry_cnt", 32'(qry6_cnt), 32'(ecnt(1)));

    // Clear sweep: event accepted alongside time_ref, a second time_ref mid-sweep,
    // and requests held asserted during the sweep must not be taken.
    time_ref = 1'b1; evt_valid = 1'b1; evt_addr = 8'd7; cur_ts = 3'd1;
    step();
    time_ref = 1'b0;
    evt_addr = 8'd3; cur_ts = 3'd4;
    qry_valid = 1'b1; qry_addr = 8'd0;
    busy = 0; done = 0; done_at = -1; cyc = 0; rdv_seen = 0;
    while (cyc < 400) begin
      if (evt_ready) break;
      busy += int'(clr_busy);
      if (clr_done) begin done++; done_at = cyc; end
      rdv_seen += int'(qry_rdata_valid);
      time_ref = (cyc == 100);
      step();
      cyc++;
    end
    evt_valid = 1'b0; qry_valid = 1'b0; time_ref = 1'b0;
    model_clear();
    chk("sweep_ready_low_cycles", 32'(cyc), 32'(N));
    chk("sweep_busy_cycles", 32'(busy), 32'(N));
    chk("sweep_done_count", 32'(done), 1);
    chk("sweep_done_last", 32'(done_at), 32'(N - 1));
    chk("sweep_no_rdata", 32'(rdv_seen), 0);
    chk("sweep_busy_after", 32'(clr_busy), 0);
    do_qry("clr_row0", 8'd0, 8'h00, 0);
    do_qry("clr_row255", 8'd255, 8'h00, 0);
    do_qry("clr_row7", 8'd7, 8'h00, 0);
    do_qry("clr_row3_blocked", 8'd3, 8'h00, 0);

    // Reset 100 cycles into a sweep
    do_evt(8'd200, 3'd2);
    do_evt(8'd10, 3'd5);
    do_qry("pre_rst", 8'd200, 8'h04, 1);
    time_ref = 1'b1;
    step();
    time_ref = 1'b0;
    repeat (100) step();
    chk("mid_sweep_busy", 32'(clr_busy), 1);
    rst = 1'b1;
    step();
    chk_reset_outs("rst_mid");
    rst = 1'b0;
    model_clear();
    step();
    do_qry("rst_row200", 8'd200, 8'h00, 0);
    do_qry("rst_row10", 8'd10, 8'h00, 0);

    // Random traffic against the array model
    last_hist = qry_hist;
    for (int i = 0; i < 400; i++) begin
      ev = 1'($urandom_range(0, 1));
      qv = 1'($urandom_range(0, 1));
      ea = 8'($urandom_range(0, 15));
      qa = ($urandom_range(0, 3) == 0) ? ea : 8'($urandom_range(0, 15));
      et = 3'($urandom_range(0, 7));
      evt_valid = ev; evt_addr = ea; cur_ts = et;
      qry_valid = qv; qry_addr = qa;
      exp_q = mh[qa];
      step();
      if (ev) mh[ea] = mh[ea] | 8'(1 << et);
      if (qv) last_hist = exp_q;
      chk("rnd_vld", 32'(qry_rdata_valid), 32'(qv));
      chk("rnd_hist", 32'(qry_hist), 32'(last_hist));
      if (qv) chk("rnd_cnt", 32'(qry_cnt), 32'(ecnt($countones(exp_q))));
    end
    evt_valid = 1'b0; qry_valid = 1'b0;
    step();
    for (int a = 0; a < 16; a++) do_qry("rnd_final", 8'(a), mh[a], $countones(mh[a]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
